// File: rtl/tt_vector_runner_pkg.sv
// Shared tester encodings and runner FSM states for the tinytester vector runner.
package tt_vector_runner_pkg;

  localparam logic [6:0] TT_IDLE = 7'h20;
  localparam logic [6:0] TT_WAIT = 7'h10;
  localparam logic [6:0] TT_PH0  = 7'h01;
  localparam logic [6:0] TT_PH1  = 7'h02;
  localparam logic [6:0] TT_PH2  = 7'h04;
  localparam logic [6:0] TT_PH3  = 7'h08;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_WAITDONE, S_RELEASE, S_RESULT, S_DRAIN, S_DONE
  } run_state_e;

  // States that abort_i may cut short (DRAIN is already heading to DONE).
  function automatic logic abortable(run_state_e s);
    return s inside {S_FETCH, S_START, S_WAITDONE, S_RELEASE, S_RESULT};
  endfunction

  // States covered by the tester watchdog.
  function automatic logic wd_state(run_state_e s);
    return s inside {S_START, S_WAITDONE, S_RELEASE};
  endfunction

endpackage

// File: rtl/tt_vec_cmp.sv
// Registered masked compare of captured pad inputs plus run-level fail statistics.
module tt_vec_cmp
  import tt_vector_runner_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             cap_i,
  input  logic [CNT_W-1:0] idx_i,
  input  logic [W-1:0]     datain_i,
  input  logic [W-1:0]     exp_i,
  input  logic [W-1:0]     mask_i,
  output logic [W-1:0]     data_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [CNT_W-1:0] first_fail_o
);

  logic [W-1:0]     data_q;
  logic             fail_q;
  logic [CNT_W-1:0] cnt_q, first_q;
  logic             miss;

  assign miss = |((datain_i ^ exp_i) & mask_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      first_q <= '1;
    end else if (clr_i) begin
      cnt_q   <= '0;
      first_q <= '1;
    end else if (cap_i) begin
      data_q <= datain_i;
      fail_q <= miss;
      if (miss) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        // An empty count means this is the run's first miscompare.
        if (cnt_q == '0) first_q <= idx_i;
      end
    end
  end

  assign data_o       = data_q;
  assign fail_o       = fail_q;
  assign fail_cnt_o   = cnt_q;
  assign first_fail_o = first_q;

endmodule

// File: rtl/tt_vector_runner.sv
// Streams test vectors into the tinytester start/wait/release handshake and
// returns one compared result per vector, with watchdog and abort handling.
module tt_vector_runner
  import tt_vector_runner_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16,
  parameter int TMO   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_vec_i,
  input  logic             vec_valid_i,
  output logic             vec_ready_o,
  input  logic [W-1:0]     vec_data_i,
  input  logic [W-1:0]     vec_oe_i,
  input  logic [W-1:0]     vec_exp_i,
  input  logic [W-1:0]     vec_mask_i,
  output logic [31:0]      tt_control_o,
  output logic [W-1:0]     tt_dataout_o,
  output logic [W-1:0]     tt_oe_o,
  input  logic [W-1:0]     tt_datain_i,
  input  logic [6:0]       tt_state_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [W-1:0]     res_data_o,
  output logic             res_fail_o,
  output logic [CNT_W-1:0] res_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [CNT_W-1:0] first_fail_o
);

  localparam int WD_W = $clog2(TMO + 1);

  run_state_e       state_q;
  logic             run_q, busy_q, done_q, err_q, ctrl_q, res_valid_q;
  logic [W-1:0]     dout_q, oe_q, exp_q, mask_q;
  logic [CNT_W-1:0] num_q, idx_q, idx_nxt;
  logic [WD_W-1:0]  wd_q;
  logic             run_start, cap, wd_go, wd_hit;

  assign idx_nxt   = idx_q + CNT_W'(1);
  assign run_start = (state_q == S_IDLE) && run_i && !run_q;
  assign cap       = (state_q == S_WAITDONE) && !abort_i && (tt_state_i == TT_WAIT);
  assign wd_hit    = (wd_q == WD_W'(TMO - 1));
  // Tester made the step this state is waiting for.
  assign wd_go     = ((state_q == S_START)    && (tt_state_i == TT_IDLE)) ||
                     ((state_q == S_WAITDONE) && (tt_state_i == TT_WAIT)) ||
                     ((state_q == S_RELEASE)  && (tt_state_i == TT_IDLE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ctrl_q      <= 1'b0;
      res_valid_q <= 1'b0;
      dout_q      <= '0;
      oe_q        <= '0;
      exp_q       <= '0;
      mask_q      <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      wd_q        <= '0;
    end else begin
      run_q  <= run_i;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (run_start) begin
          num_q   <= num_vec_i;
          idx_q   <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= (num_vec_i == '0) ? S_DONE : S_FETCH;
        end
        S_FETCH: if (vec_valid_i && vec_ready_o) begin
          dout_q  <= vec_data_i;
          oe_q    <= vec_oe_i;
          exp_q   <= vec_exp_i;
          mask_q  <= vec_mask_i;
          wd_q    <= '0;
          state_q <= S_START;
        end
        S_START: if (wd_go) begin
          ctrl_q  <= 1'b1;
          wd_q    <= '0;
          state_q <= S_WAITDONE;
        end
        S_WAITDONE: if (wd_go) begin
          ctrl_q  <= 1'b0;
          wd_q    <= '0;
          state_q <= S_RELEASE;
        end
        S_RELEASE: if (wd_go) begin
          res_valid_q <= 1'b1;
          state_q     <= S_RESULT;
        end
        S_RESULT: if (res_ready_i) begin
          res_valid_q <= 1'b0;
          idx_q       <= idx_nxt;
          state_q     <= (idx_nxt == num_q) ? S_DONE : S_FETCH;
        end
        S_DRAIN: if (tt_state_i == TT_IDLE) state_q <= S_DONE;
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (wd_state(state_q) && !wd_go) begin
        if (wd_hit) begin
          err_q   <= 1'b1;
          ctrl_q  <= 1'b0;
          state_q <= S_DRAIN;
        end else begin
          wd_q <= wd_q + WD_W'(1);
        end
      end

      // Abort wins over both normal progress and the watchdog.
      if (abort_i && abortable(state_q)) begin
        ctrl_q      <= 1'b0;
        res_valid_q <= 1'b0;
        state_q     <= S_DRAIN;
      end
    end
  end

  assign vec_ready_o  = (state_q == S_FETCH) && !abort_i;
  assign tt_control_o = {31'b0, ctrl_q};
  assign tt_dataout_o = dout_q;
  assign tt_oe_o      = oe_q;
  assign res_valid_o  = res_valid_q;
  assign res_idx_o    = idx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

  tt_vec_cmp #(.W(W), .CNT_W(CNT_W)) u_cmp (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (run_start),
    .cap_i        (cap),
    .idx_i        (idx_q),
    .datain_i     (tt_datain_i),
    .exp_i        (exp_q),
    .mask_i       (mask_q),
    .data_o       (res_data_o),
    .fail_o       (res_fail_o),
    .fail_cnt_o   (fail_cnt_o),
    .first_fail_o (first_fail_o)
  );

endmodule

// File: tb/tb_tt_vector_runner.sv
// Scoreboard bench for tt_vector_runner with a behavioural tinytester and pad loopback.
module tb_tt_vector_runner;
  import tt_vector_runner_pkg::*;

  localparam int W = 32, CNT_W = 16, TMO = 64;
  localparam logic [W-1:0] PULL = 32'h3C5A_0F96;

  logic             clk = 1'b0, rst = 1'b1;
  logic             run_i = 1'b0, abort_i = 1'b0;
  logic [CNT_W-1:0] num_vec_i = '0;
  logic             vec_valid_i = 1'b0, vec_ready_o;
  logic [W-1:0]     vec_data_i = '0, vec_oe_i = '0, vec_exp_i = '0, vec_mask_i = '0;
  logic [31:0]      tt_control_o;
  logic [W-1:0]     tt_dataout_o, tt_oe_o, tt_datain_i;
  logic [6:0]       tt_state_i;
  logic             res_valid_o, res_ready_i = 1'b0, res_fail_o;
  logic [W-1:0]     res_data_o;
  logic [CNT_W-1:0] res_idx_o, fail_cnt_o, first_fail_o;
  logic             busy_o, done_o, err_o;

  tt_vector_runner #(.W(W), .CNT_W(CNT_W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .run_i(run_i), .abort_i(abort_i), .num_vec_i(num_vec_i),
    .vec_valid_i(vec_valid_i), .vec_ready_o(vec_ready_o), .vec_data_i(vec_data_i),
    .vec_oe_i(vec_oe_i), .vec_exp_i(vec_exp_i), .vec_mask_i(vec_mask_i),
    .tt_control_o(tt_control_o), .tt_dataout_o(tt_dataout_o), .tt_oe_o(tt_oe_o),
    .tt_datain_i(tt_datain_i), .tt_state_i(tt_state_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_fail_o(res_fail_o),
    .res_idx_o(res_idx_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .fail_cnt_o(fail_cnt_o), .first_fail_o(first_fail_o)
  );

  always #5 clk = ~clk;

  // Tester: start from IDLE walks PHASE0..3 into WAIT, release returns to IDLE.
  logic [6:0] tst;
  bit stuck = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) tst <= TT_IDLE;
    else case (tst)
      TT_IDLE: if (tt_control_o[0]) tst <= TT_PH0;
      TT_PH0:  tst <= TT_PH1;
      TT_PH1:  tst <= TT_PH2;
      TT_PH2:  if (!stuck) tst <= TT_PH3;
      TT_PH3:  tst <= TT_WAIT;
      TT_WAIT: if (!tt_control_o[0]) tst <= TT_IDLE;
      default: tst <= TT_IDLE;
    endcase
  end
  assign tt_state_i  = tst;
  assign tt_datain_i = (tt_dataout_o & tt_oe_o) | (~tt_oe_o & PULL);

  typedef struct { logic [W-1:0] d, oe, ex, m; } vec_t;
  typedef struct { logic [W-1:0] data; logic fail; logic [CNT_W-1:0] idx; } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, res_seen = 0, fetch_cnt = 0;
  logic [CNT_W-1:0] m_fcnt, m_first;
  bit run_over, hold_ready = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  function automatic logic [W-1:0] pad(input vec_t v);
    return (v.d & v.oe) | (~v.oe & PULL);
  endfunction

  function automatic vec_t mk(input logic [W-1:0] d, oe, ex, m);
    vec_t v;
    v.d = d; v.oe = oe; v.ex = ex; v.m = m;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [W-1:0] flip;
    v.d  = $urandom;
    v.oe = $urandom;
    v.m  = ($urandom_range(0, 1) == 1) ? W'($urandom) : '1;
    flip = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
    v.ex = pad(v) ^ flip;
    return v;
  endfunction

  always @(posedge clk) begin
    #1;
    res_ready_i = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!rst && vec_valid_i && vec_ready_o) fetch_cnt++;
  end

  // Monitor: every accepted result is checked against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid_o && res_ready_i) begin
      res_seen++;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_result: got idx %0d, want none", res_idx_o);
      end else begin
        e = sb.pop_front();
        chk("res_data", res_data_o, e.data);
        chk("res_fail", res_fail_o, e.fail);
        chk("res_idx", res_idx_o, e.idx);
      end
    end
  end

  // Offer each vector; on acceptance push its expected result and update stats.
  task automatic drive_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      int t;
      exp_t e;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      vec_valid_i = 1'b1;
      vec_data_i = vecs[i].d; vec_oe_i = vecs[i].oe;
      vec_exp_i = vecs[i].ex; vec_mask_i = vecs[i].m;
      t = 0;
      while (1) begin
        @(negedge clk);
        if (vec_ready_o || run_over || t > 400) break;
        t++;
      end
      if (!vec_ready_o) begin
        vec_valid_i = 1'b0;
        if (!run_over) chk("vec_accept_timeout", 0, 1);
        return;
      end
      e.data = pad(vecs[i]);
      e.fail = |((e.data ^ vecs[i].ex) & vecs[i].m);
      e.idx  = CNT_W'(i);
      if (e.fail) begin
        if (m_fcnt == '0) m_first = CNT_W'(i);
        if (m_fcnt != '1) m_fcnt = m_fcnt + 1'b1;
      end
      sb.push_back(e);
      @(posedge clk); #1;
      vec_valid_i = 1'b0;
    end
  endtask

  task automatic start_run(input int n);
    run_over = 1'b0;
    m_fcnt = '0; m_first = '1;
    num_vec_i = CNT_W'(n);
    run_i = 1'b1;
    @(posedge clk); #1;
    run_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done_o && cyc < budget) begin @(negedge clk); cyc++; end
    chk("done_seen", done_o, 1);
  endtask

  task automatic full_run(input int n, output int cyc);
    start_run(n);
    fork
      drive_vecs();
      begin wait_done(2000, cyc); run_over = 1'b1; end
    join
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_fail_cnt"}, fail_cnt_o, m_fcnt);
    chk({tag, "_first_fail"}, first_fail_o, m_first);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  int cyc, base, t, f0;
  bit ok_v, ok_d, no_rdy, no_ctrl;
  logic [W-1:0] snap_d;
  logic [CNT_W-1:0] snap_i;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_ctrl", tt_control_o, 0);
    chk("rst_first_fail", first_fail_o, 16'hFFFF);
    chk("rst_outs", {res_valid_o, done_o, err_o, vec_ready_o, fail_cnt_o, res_idx_o}, 0);
    chk("rst_data", {tt_dataout_o, tt_oe_o, res_data_o}, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Matching vectors: three passes, and a run of at least 27 cycles.
    vecs = {};
    repeat (3) vecs.push_back(mk(32'hA5A5A5A5, '1, 32'hA5A5A5A5, '1));
    full_run(3, cyc);
    chk("t1_latency_ge27", cyc >= 27, 1);
    end_checks("t1");

    // Bit 4 miscompare on vector 1, then the same vector with bit 4 masked off.
    vecs[1] = mk(32'hA5A5A5A5, '1, 32'hA5A5A5B5, '1);
    full_run(3, cyc);
    end_checks("t2a");
    chk("t2a_cnt_is1", fail_cnt_o, 1);
    vecs[1].m = ~32'h10;
    full_run(3, cyc);
    end_checks("t2b");

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 6);
      vecs = {};
      repeat (n) vecs.push_back(rand_vec());
      full_run(n, cyc);
      end_checks("rand");
    end

    // Consumer stall: result held, nothing else moves.
    vecs = {rand_vec(), rand_vec()};
    hold_ready = 1'b1;
    start_run(2);
    fork
      drive_vecs();
      begin
        t = 0;
        while (!res_valid_o && t < 100) begin @(negedge clk); t++; end
        chk("t3_res_valid", res_valid_o, 1);
        snap_d = res_data_o; snap_i = res_idx_o; f0 = fetch_cnt;
        ok_v = 1; ok_d = 1; no_rdy = 1; no_ctrl = 1;
        repeat (20) begin
          @(negedge clk);
          ok_v &= res_valid_o;
          ok_d &= (res_data_o == snap_d) && (res_idx_o == snap_i);
          no_rdy &= !vec_ready_o;
          no_ctrl &= !tt_control_o[0];
        end
        chk("t3_valid_held", ok_v, 1);
        chk("t3_data_held", ok_d, 1);
        chk("t3_no_ready", no_rdy, 1);
        chk("t3_no_start", no_ctrl, 1);
        chk("t3_no_fetch", fetch_cnt - f0, 0);
        hold_ready = 1'b0;
        wait_done(500, cyc);
        run_over = 1'b1;
      end
    join
    end_checks("t3");

    // Tester stuck in PHASE2: watchdog error, no result.
    vecs = {mk(32'h1234_5678, '1, 32'h1234_5678, '1)};
    base = res_seen;
    stuck = 1'b1;
    start_run(1);
    fork
      drive_vecs();
      begin
        t = 0;
        while (!err_o && t < TMO + 40) begin @(negedge clk); t++; end
        chk("t4_err", err_o, 1);
        chk("t4_not_early", t >= TMO, 1);
        chk("t4_ctrl_low", tt_control_o[0], 0);
        stuck = 1'b0;
        wait_done(100, cyc);
        run_over = 1'b1;
      end
    join
    chk("t4_no_result", res_seen - base, 0);
    chk("t4_err_sticky", err_o, 1);
    chk("t4_accepted", sb.size(), 1);
    sb.delete();

    // Abort during vector 1's WAITDONE; vector 0 miscompares.
    vecs = {mk(32'hFFFF_0000, '1, 32'hFFFF_0001, '1), mk(32'h0F0F_0F0F, '1, 32'h0F0F_0F0F, '1),
            rand_vec()};
    base = res_seen;
    start_run(3);
    fork
      drive_vecs();
      begin
        t = 0;
        while (res_seen != base + 1 && t < 200) begin @(negedge clk); t++; end
        t = 0;
        while (tst != TT_PH1 && t < 60) begin @(negedge clk); t++; end
        chk("t5_ctrl_before", tt_control_o[0], 1);
        @(posedge clk); #1; abort_i = 1'b1;
        @(posedge clk); #1; abort_i = 1'b0;
        chk("t5_ctrl_dropped", tt_control_o[0], 0);
        wait_done(100, cyc);
        run_over = 1'b1;
      end
    join
    chk("t5_results", res_seen - base, 1);
    chk("t5_idx", res_idx_o, 1);
    chk("t5_dropped", sb.size(), 1);
    sb.delete();
    end_checks("t5");

    // Reset while a result is pending.
    vecs = {mk(32'h0, '1, 32'h8000_0000, '1)};
    hold_ready = 1'b1;
    start_run(1);
    fork
      drive_vecs();
      begin
        t = 0;
        while (!res_valid_o && t < 100) begin @(negedge clk); t++; end
        chk("t6_pre_cnt", fail_cnt_o, 1);
        #2; rst = 1'b1; #1;
        chk("t6_valid", res_valid_o, 0);
        chk("t6_busy_ctrl", {busy_o, tt_control_o}, 0);
        chk("t6_cnt", fail_cnt_o, 0);
        chk("t6_first_fail", first_fail_o, 16'hFFFF);
        chk("t6_data", {tt_dataout_o, res_data_o, res_idx_o}, 0);
        run_over = 1'b1;
      end
    join
    sb.delete();
    @(posedge clk); #1; rst = 1'b0; hold_ready = 1'b0;

    // Empty run.
    f0 = fetch_cnt;
    vecs = {};
    full_run(0, cyc);
    chk("t7_no_fetch", fetch_cnt - f0, 0);
    @(negedge clk);
    chk("t7_idle", {busy_o, done_o}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
